// File: rtl/rtc_pkg.sv
// Shared widths, limits, time record and time helpers for the RTC timekeeper.
package rtc_pkg;

    localparam int unsigned SEC_W     = 6;
    localparam int unsigned MIN_W     = 6;
    localparam int unsigned HR_W      = 5;

    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned HR_MAX    = 23;
    localparam int unsigned HR12_NOON = 12;

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } time_t;

    // True when every field of t is a legal time of day.
    function automatic logic time_valid(time_t t);
        return (t.hr <= HR_W'(HR_MAX)) && (t.min <= MIN_W'(MIN_MAX)) &&
               (t.sec <= SEC_W'(SEC_MAX));
    endfunction

    // One-second advance with the full sec -> min -> hr carry resolved at once.
    function automatic time_t time_inc(time_t t);
        time_t n;
        n = t;
        if (t.sec == SEC_W'(SEC_MAX)) begin
            n.sec = '0;
            if (t.min == MIN_W'(MIN_MAX)) begin
                n.min = '0;
                n.hr  = (t.hr == HR_W'(HR_MAX)) ? '0 : t.hr + 1'b1;
            end else begin
                n.min = t.min + 1'b1;
            end
        end else begin
            n.sec = t.sec + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Load/alarm bus of the RTC timekeeper. Optional alarm signals exist only
// when RTC_ALARM_EN is defined.
interface rtc_timekeeper_if;
    import rtc_pkg::*;

    logic             set_en;
    logic [HR_W-1:0]  set_hr;
    logic [MIN_W-1:0] set_min;
    logic [SEC_W-1:0] set_sec;
    logic             set_err;
`ifdef RTC_ALARM_EN
    logic             alarm_set;
    logic [HR_W-1:0]  alarm_hr;
    logic [MIN_W-1:0] alarm_min;
    logic             alarm_on;
    logic             alarm;

    modport master (output set_en, set_hr, set_min, set_sec,
                    output alarm_set, alarm_hr, alarm_min, alarm_on,
                    input  set_err, alarm);
    modport slave  (input  set_en, set_hr, set_min, set_sec,
                    input  alarm_set, alarm_hr, alarm_min, alarm_on,
                    output set_err, alarm);
`else
    modport master (output set_en, set_hr, set_min, set_sec, input  set_err);
    modport slave  (input  set_en, set_hr, set_min, set_sec, output set_err);
`endif

endinterface

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ running cycles.
// Holds its count while run is low; clr restarts the second.
module rtc_prescaler #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned TICK_W = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(CLK_HZ - 1);

    logic [TICK_W-1:0] count_q, count_d;

    assign tick = run && (count_q == LAST);

    // Next count: clear wins, wrap on tick, otherwise count only while running.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Hours/minutes/seconds timekeeper with run control, validated load,
// 12/24-hour display and second/day pulses. Define RTC_ALARM_EN to add
// the hh:mm alarm.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned TICK_W = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              mode_12h,
    rtc_timekeeper_if.slave   bus,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HR_W-1:0]   hr,
    output logic              pm,
    output logic              sec_tick,
    output logic              day_tick
);

    time_t time_q, time_d, load, time_next;
    logic  tick, set_valid;
    logic  sec_tick_q, sec_tick_d, day_tick_q, day_tick_d, set_err_q, set_err_d;

    assign load      = '{hr: bus.set_hr, min: bus.set_min, sec: bus.set_sec};
    assign set_valid = bus.set_en && time_valid(load);
    assign time_next = time_inc(time_q);

    rtc_prescaler #(
        .CLK_HZ (CLK_HZ),
        .TICK_W (TICK_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clr  (set_valid),
        .tick (tick)
    );

`ifdef RTC_ALARM_EN
    time_t alarm_q, alarm_d, alarm_load;
    logic  alarm_valid, alarm_fire_q, alarm_fire_d;

    assign alarm_load  = '{hr: bus.alarm_hr, min: bus.alarm_min, sec: '0};
    assign alarm_valid = bus.alarm_set && time_valid(alarm_load);
`endif

    // Next time: a valid load beats a same-cycle tick; an invalid one does not.
    always_comb begin
        time_d     = time_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        set_err_d  = bus.set_en && !set_valid;
        if (set_valid) begin
            time_d = load;
        end else if (tick) begin
            time_d     = time_next;
            sec_tick_d = 1'b1;
            day_tick_d = (time_next == '0);
        end
`ifdef RTC_ALARM_EN
        set_err_d    = set_err_d || (bus.alarm_set && !alarm_valid);
        alarm_d      = alarm_valid ? alarm_load : alarm_q;
        alarm_fire_d = sec_tick_d && bus.alarm_on && (time_d == alarm_q);
`endif
    end

    // Time and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q     <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            time_q     <= time_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            set_err_q  <= set_err_d;
        end
    end

`ifdef RTC_ALARM_EN
    // Alarm setpoint and fire pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q      <= '0;
            alarm_fire_q <= 1'b0;
        end else begin
            alarm_q      <= alarm_d;
            alarm_fire_q <= alarm_fire_d;
        end
    end

    assign bus.alarm = alarm_fire_q;
`endif

    // Hour display mapping; internal hour always stays 0..23.
    always_comb begin
        if (!mode_12h) begin
            hr = time_q.hr;
        end else if (time_q.hr == '0) begin
            hr = HR_W'(HR12_NOON);
        end else if (time_q.hr > HR_W'(HR12_NOON)) begin
            hr = time_q.hr - HR_W'(HR12_NOON);
        end else begin
            hr = time_q.hr;
        end
    end

    assign pm          = (time_q.hr >= HR_W'(HR12_NOON));
    assign sec         = time_q.sec;
    assign min         = time_q.min;
    assign sec_tick    = sec_tick_q;
    assign day_tick    = day_tick_q;
    assign bus.set_err = set_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper with CLK_HZ = 4. A behavioural
// model produces the expected outputs for each clock edge into a queue;
// each scenario task pops and compares them.
module tb_rtc_timekeeper;

    localparam int CLK_HZ = 4;

    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hr;
        logic       pm;
        logic       stk;
        logic       dtk;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst, run, mode_12h;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic pm, sec_tick, day_tick;
    logic [20:0] obs;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model state.
    int m_pre, m_h, m_m, m_s;
    bit m_stk, m_dtk, m_err;

    rtc_timekeeper_if bus ();

    rtc_timekeeper #(
        .CLK_HZ (CLK_HZ),
        .TICK_W (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mode_12h (mode_12h),
        .bus      (bus),
        .sec      (sec),
        .min      (min),
        .hr       (hr),
        .pm       (pm),
        .sec_tick (sec_tick),
        .day_tick (day_tick)
    );

    always #5 clk = ~clk;

    assign obs = {sec, min, hr, pm, sec_tick, day_tick, bus.set_err};

    function automatic int disp(int h, bit m12);
        if (!m12)   return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic model_reset();
        m_pre = 0; m_h = 0; m_m = 0; m_s = 0;
        m_stk = 0; m_dtk = 0; m_err = 0;
    endtask

    // Advance the model over one edge, queue its prediction, clock the DUT.
    task automatic step();
        exp_t e;
        bit   tk, ok;
        tk = run && (m_pre == CLK_HZ - 1);
        ok = bus.set_en && (int'(bus.set_hr) <= 23) && (int'(bus.set_min) <= 59) &&
             (int'(bus.set_sec) <= 59);
        m_err = bus.set_en && !ok;
        m_stk = 0;
        m_dtk = 0;
        if (ok) begin
            m_h = int'(bus.set_hr); m_m = int'(bus.set_min); m_s = int'(bus.set_sec);
            m_pre = 0;
        end else begin
            if (run) m_pre = tk ? 0 : m_pre + 1;
            if (tk) begin
                m_stk = 1;
                m_s = m_s + 1;
                if (m_s == 60) begin m_s = 0; m_m = m_m + 1; end
                if (m_m == 60) begin m_m = 0; m_h = m_h + 1; end
                if (m_h == 24) m_h = 0;
                m_dtk = (m_h == 0) && (m_m == 0) && (m_s == 0);
            end
        end
        e.sec = 6'(m_s);
        e.min = 6'(m_m);
        e.hr  = 5'(disp(m_h, mode_12h));
        e.pm  = (m_h >= 12);
        e.stk = m_stk;
        e.dtk = m_dtk;
        e.err = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.set_en = 1'b0;
    endtask

    task automatic set_time(int h, int m, int s);
        bus.set_hr  = 5'(h);
        bus.set_min = 6'(m);
        bus.set_sec = 6'(s);
        bus.set_en  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; mode_12h = 1'b0;
        set_time(0, 0, 0);
        bus.set_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs !== 21'h0) begin
            n_bad++;
            $display("FAIL reset24 got=%h exp=%h", obs, 21'h0);
        end
        mode_12h = 1'b1;
        #1;
        n_vec++;
        if (hr !== 5'd12 || pm !== 1'b0) begin
            n_bad++;
            $display("FAIL reset12 got hr=%0d pm=%0b exp hr=12 pm=0", hr, pm);
        end
        mode_12h = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_count();
        exp_t e;
        int   nst = 0;
        run = 1'b1;
        for (int i = 1; i <= 240; i++) begin
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL count cyc=%0d got=%h exp=%h", i, obs, e);
            end
            if (sec_tick) nst++;
            if (i == 236) begin
                n_vec++;
                if (sec !== 6'd59 || min !== 6'd0) begin
                    n_bad++;
                    $display("FAIL count236 got %0d:%0d exp 0:59", min, sec);
                end
            end
        end
        n_vec++;
        if (sec !== 6'd0 || min !== 6'd1 || nst != 60) begin
            n_bad++;
            $display("FAIL count240 got %0d:%0d ticks=%0d exp 1:0 ticks=60", min, sec, nst);
        end
    endtask

    task automatic test_day_roll();
        exp_t e;
        int   ndt = 0;
        run = 1'b1;
        set_time(23, 59, 58);
        for (int i = 0; i <= 8; i++) begin
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL dayroll cyc=%0d got=%h exp=%h", i, obs, e);
            end
            if (day_tick) begin
                ndt++;
                n_vec++;
                if (sec_tick !== 1'b1) begin
                    n_bad++;
                    $display("FAIL daytick_sectick got sec_tick=%0b exp 1", sec_tick);
                end
            end
        end
        n_vec++;
        if (ndt != 1 || hr !== 5'd0 || min !== 6'd0 || sec !== 6'd0) begin
            n_bad++;
            $display("FAIL dayroll_end got %0d:%0d:%0d day_ticks=%0d exp 0:0:0 day_ticks=1",
                     hr, min, sec, ndt);
        end
    endtask

    task automatic test_bad_load();
        exp_t e;
        run = 1'b0;
        set_time(5, 5, 60);
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e || bus.set_err !== (i == 0)) begin
                n_bad++;
                $display("FAIL badload cyc=%0d got=%h exp=%h", i, obs, e);
            end
        end
        mode_12h = 1'b1;
        set_time(12, 0, 0);
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e || hr !== 5'd12 || pm !== 1'b1) begin
            n_bad++;
            $display("FAIL noon got=%h hr=%0d pm=%0b exp=%h hr=12 pm=1", obs, hr, pm, e);
        end
    endtask

    task automatic test_display();
        exp_t e;
        int   tbl[6][4] = '{'{0, 1, 12, 0}, '{13, 1, 1, 1}, '{0, 0, 0, 0},
                            '{13, 0, 13, 1}, '{23, 1, 11, 1}, '{12, 0, 12, 1}};
        run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mode_12h = tbl[i][1][0];
            set_time(tbl[i][0], 34, 56);
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e || int'(hr) != tbl[i][2] || int'(pm) != tbl[i][3]) begin
                n_bad++;
                $display("FAIL display h24=%0d m12=%0d got hr=%0d pm=%0b exp hr=%0d pm=%0d",
                         tbl[i][0], tbl[i][1], hr, pm, tbl[i][2], tbl[i][3]);
            end
        end
        mode_12h = 1'b0;
    endtask

    task automatic test_pause();
        exp_t e;
        int   nst = 0;
        int   k;
        run = 1'b1;
        set_time(1, 2, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL preload cyc=%0d got=%h exp=%h", i, obs, e);
            end
        end
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            e = exp_q.pop_front();
            if (sec_tick) nst++;
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL pause cyc=%0d got=%h exp=%h", i, obs, e);
            end
        end
        n_vec++;
        if (nst != 0) begin
            n_bad++;
            $display("FAIL pause_ticks got=%0d exp=0", nst);
        end
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e || sec_tick !== (i == 1) || sec !== ((i == 1) ? 6'd4 : 6'd3)) begin
                n_bad++;
                $display("FAIL resume cyc=%0d got=%h exp=%h", i, obs, e);
            end
        end
        // Walk to the cycle with a pending tick, then load on top of it.
        k = 0;
        while (m_pre != CLK_HZ - 1 && k < 2 * CLK_HZ) begin
            step();
            e = exp_q.pop_front();
            k++;
        end
        n_vec++;
        if (m_pre != CLK_HZ - 1) begin
            n_bad++;
            $display("FAIL tick_search got pre=%0d exp=%0d", m_pre, CLK_HZ - 1);
        end
        set_time(7, 8, 9);
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e || sec !== 6'd9 || min !== 6'd8 || sec_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL load_vs_tick got=%h exp=%h", obs, e);
        end
        for (int i = 0; i < CLK_HZ; i++) begin
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL postload cyc=%0d got=%h exp=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_async();
        exp_t e;
        run = 1'b1;
        set_time(10, 20, 30);
        step();
        e = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front();
        end
        n_vec++;
        if (obs !== e || m_pre != 2) begin
            n_bad++;
            $display("FAIL prereset got=%h pre=%0d exp=%h pre=2", obs, m_pre, e);
        end
        set_time(1, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (obs !== 21'h0) begin
            n_bad++;
            $display("FAIL async_reset got=%h exp=%h", obs, 21'h0);
        end
        bus.set_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < CLK_HZ; i++) begin
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL postreset cyc=%0d got=%h exp=%h", i, obs, e);
            end
        end
        n_vec++;
        if (sec !== 6'd1 || min !== 6'd0 || hr !== 5'd0) begin
            n_bad++;
            $display("FAIL lost_set got %0d:%0d:%0d exp 0:0:1", hr, min, sec);
        end
    endtask

    initial begin
        bus.set_en = 1'b0;
`ifdef RTC_ALARM_EN
        bus.alarm_set = 1'b0;
        bus.alarm_hr  = '0;
        bus.alarm_min = '0;
        bus.alarm_on  = 1'b0;
`endif
        test_reset();
        test_count();
        test_day_roll();
        test_bad_load();
        test_display();
        test_pause();
        test_reset_async();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
